guess_solver: RTL

GUESS_SOLVER -- requirements
Module: guess_solver

---
 rtl/guess_solver_pkg.sv | 19 +
 rtl/guess_solver_bc_score.sv | 28 ++
 rtl/guess_solver.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/guess_solver_pkg.sv
// Shared types and constants for the two-digit guess solver.
package guess_solver_pkg;

  localparam int unsigned NUM_CAND = 100;
  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned IDX_W    = $clog2(NUM_CAND);

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GUESS,
    ST_PRUNE,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/guess_solver_bc_score.sv
// Combinational bulls/cows style score of a guess against one candidate.
module bc_score
  import guess_solver_pkg::*;
(
  input  bcd_t       i_g_a,  // guess ones digit
  input  bcd_t       i_g_b,  // guess tens digit
  input  bcd_t       i_s0,   // candidate ones digit
  input  bcd_t       i_s1,   // candidate tens digit
  output logic [1:0] o_a,
  output logic [1:0] o_b
);

  // Repeated-digit guesses only count positional hits; otherwise each guess
  // digit scores at most once, exact position taking priority.
  always_comb begin
    o_a = '0;
    o_b = '0;
    if (i_g_a == i_g_b) begin
      o_a = {1'b0, i_g_a == i_s0} + {1'b0, i_g_b == i_s1};
    end else begin
      if (i_g_a == i_s0)      o_a = o_a + 2'd1;
      else if (i_g_a == i_s1) o_b = o_b + 2'd1;
      if (i_g_b == i_s1)      o_a = o_a + 2'd1;
      else if (i_g_b == i_s0) o_b = o_b + 2'd1;
    end
  end

endmodule

// File: rtl/guess_solver.sv
// Two-digit secret solver: issues guesses, prunes the 100-entry candidate
// map against each feedback, and guesses the lowest surviving candidate.
module guess_solver
  import guess_solver_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               fb_valid,
  input  logic [1:0]         fb_A,
  input  logic [1:0]         fb_B,
  output logic               guess_valid,
  output logic [DIGIT_W-1:0] guess_a,
  output logic [DIGIT_W-1:0] guess_b,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [CNT_W-1:0]   guess_count
);

  state_e              r_state, w_next;
  logic [NUM_CAND-1:0] r_alive;
  logic [IDX_W-1:0]    r_idx;
  bcd_t                r_scan_t, r_scan_o;
  bcd_t                r_surv_t, r_surv_o;
  logic                r_found;
  bcd_t                r_guess_a, r_guess_b;
  logic [1:0]          r_fb_a, r_fb_b;
  logic [CNT_W-1:0]    r_count;

  logic [1:0]          w_sc_a, w_sc_b;
  logic                w_match, w_keep, w_last, w_any;

  bc_score u_score (
    .i_g_a (r_guess_a),
    .i_g_b (r_guess_b),
    .i_s0  (r_scan_o),
    .i_s1  (r_scan_t),
    .o_a   (w_sc_a),
    .o_b   (w_sc_b)
  );

  assign w_match = (w_sc_a == r_fb_a) && (w_sc_b == r_fb_b);
  assign w_keep  = r_alive[r_idx] && w_match;
  assign w_last  = (r_scan_t == 4'd9) && (r_scan_o == 4'd9);
  // candidate 99 is still being judged on the final scan cycle
  assign w_any   = r_found || w_keep;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_GUESS;
      ST_GUESS: if (fb_valid) w_next = (fb_A == 2'd2) ? ST_DONE : ST_PRUNE;
      ST_PRUNE: if (w_last) w_next = w_any ? ST_GUESS : ST_ERROR;
      ST_DONE:  if (start) w_next = ST_GUESS;
      ST_ERROR: if (start) w_next = ST_GUESS;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Candidate map, scan counters, feedback capture and guess register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alive   <= '1;
      r_idx     <= '0;
      r_scan_t  <= '0;
      r_scan_o  <= '0;
      r_surv_t  <= '0;
      r_surv_o  <= '0;
      r_found   <= 1'b0;
      r_guess_a <= '0;
      r_guess_b <= '0;
      r_fb_a    <= '0;
      r_fb_b    <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_alive   <= '1;
            r_guess_a <= '0;
            r_guess_b <= '0;
            r_count   <= 7'd1;
          end
        end
        ST_GUESS: begin
          if (fb_valid) begin
            r_fb_a   <= fb_A;
            r_fb_b   <= fb_B;
            r_idx    <= '0;
            r_scan_t <= '0;
            r_scan_o <= '0;
            r_found  <= 1'b0;
          end
        end
        ST_PRUNE: begin
          if (!w_match) r_alive[r_idx] <= 1'b0;
          if (w_keep && !r_found) begin
            r_found  <= 1'b1;
            r_surv_t <= r_scan_t;
            r_surv_o <= r_scan_o;
          end
          if (w_last) begin
            r_idx    <= '0;
            r_scan_t <= '0;
            r_scan_o <= '0;
            if (r_found) begin
              r_guess_a <= r_surv_o;
              r_guess_b <= r_surv_t;
            end else if (w_keep) begin
              r_guess_a <= r_scan_o;
              r_guess_b <= r_scan_t;
            end
            if (w_any && (r_count != '1)) r_count <= r_count + 7'd1;
          end else begin
            r_idx <= r_idx + 7'd1;
            if (r_scan_o == 4'd9) begin
              r_scan_o <= '0;
              r_scan_t <= r_scan_t + 4'd1;
            end else begin
              r_scan_o <= r_scan_o + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign guess_valid = (r_state == ST_GUESS);
  assign busy        = (r_state == ST_GUESS) || (r_state == ST_PRUNE);
  assign done        = (r_state == ST_DONE);
  assign error       = (r_state == ST_ERROR);
  assign guess_a     = r_guess_a;
  assign guess_b     = r_guess_b;
  assign guess_count = r_count;

endmodule
